button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front-end conditioner for each Nexys A7 pushbutton, placed directly upstream of the digital watch FSM.
- Synchronises the raw button input and debounces it. Produces a single-cycle press tick, a release tick and a held level.
- After a long hold it produces auto-repeat ticks, so Start/Lap held during timer set mode steps the minute or second field continuously.
- tick_out drops into the FSM's existing one-cycle button-tick inputs.

Parameters:
- CLK_FREQ, 100_000_000, clock frequency in Hz.
- DEBOUNCE_MS, 20, stable time required on press and on release.
- HOLD_MS, 500, continuous hold before long_hold asserts and auto-repeat starts.
- REPEAT_MS, 100, auto-repeat period.
- REPEAT_EN, 1, 1 enables repeat ticks on tick_out; 0 means tick_out = press_tick only.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- button_in  in  1  raw asynchronous button.
- tick_out  out  1  one-cycle pulse: press_tick OR repeat tick (FSM consumer).
- press_tick  out  1  one-cycle pulse on debounced press.
- release_tick  out  1  one-cycle pulse on debounced release.
- held  out  1  debounced button level.
- long_hold  out  1  high once the hold exceeds HOLD_MS, until release completes.

Behaviour:
- Interface (decided): one clock, clk. Reset is synchronous and active-low, on reset_n. All state updates on posedge clk only.
- Derived constants:
  - DB_CYC = CLK_FREQ/1000*DEBOUNCE_MS.
  - HOLD_CYC = CLK_FREQ/1000*HOLD_MS.
  - REP_CYC = CLK_FREQ/1000*REPEAT_MS.
  - Each must be at least 1.
  - Counter width is $clog2 of the largest constant, plus 1.
- Synchroniser: 2 flops. sync = second flop. Sync flops reset to 0.
- All outputs are registered. With reset_n=0 at an edge, every output, counter and sync flop goes to 0 and the FSM goes to IDLE. This includes reset mid-hold: no release_tick is emitted.
- IDLE:
  - sync=1 → PRESS_WAIT with cnt=1.
- PRESS_WAIT:
  - sync=0 → IDLE, no tick.
  - cnt==DB_CYC with sync=1 → PRESSED: press_tick<=1, held<=1, hold_cnt<=0.
  - otherwise cnt++.
- Press latency: button_in sampled high at edge N and stable → press_tick high in the cycle after edge N+2+DB_CYC.
- PRESSED:
  - sync=0 → RELEASE_WAIT with cnt=1.
  - hold_cnt==HOLD_CYC-1 → REPEATING: long_hold<=1, rep_cnt<=0, and one repeat tick if REPEAT_EN.
  - otherwise hold_cnt++.
- REPEATING:
  - sync=0 → RELEASE_WAIT with cnt=1.
  - rep_cnt==REP_CYC-1 → repeat tick (if REPEAT_EN), rep_cnt<=0.
  - otherwise rep_cnt++.
- RELEASE_WAIT:
  - sync=1 (bounce) → return to REPEATING if long_hold, else PRESSED. hold_cnt/rep_cnt were frozen during RELEASE_WAIT and resume from their frozen values. No new press_tick.
  - cnt==DB_CYC with sync=0 → IDLE: release_tick<=1, held<=0, long_hold<=0.
  - otherwise cnt++.
- Pulses:
  - press_tick, release_tick and repeat ticks are exactly 1 cycle wide, then cleared.
  - tick_out = press_tick | repeat_tick, registered in the same cycle. press_tick and a repeat tick never coincide.
- held is 1 in PRESSED, REPEATING and RELEASE_WAIT.
- Glitches shorter than DB_CYC samples produce no output in either direction.
- No counter wraps. Each counter saturates by state exit.

Test Plan:
All scenarios use CLK_FREQ=1000, DEBOUNCE_MS=4, HOLD_MS=20, REPEAT_MS=5, REPEAT_EN=1, so DB_CYC=4, HOLD_CYC=20, REP_CYC=5.
1. Reset: reset_n=0 for 3 cycles with button_in=1 → all outputs 0. After release of reset, press_tick appears 6 cycles after reset_n rises.
2. Clean press then release, held 10 cycles → press_tick one pulse 6 cycles after the rise; held=1. release_tick one pulse 6 cycles after the fall; held=0; long_hold stays 0; tick_out pulses once.
3. Bounce: pulses of 1 then 2 cycles high, each separated by 1 low cycle → no press_tick, held=0. A 3-cycle low glitch while held → no release_tick, and no second press_tick.
4. Long hold for 60 cycles → press_tick at cycle 6. long_hold and the first repeat at cycle 26. Further repeats at 31, 36, ... up to release. tick_out pulse count = 1 + repeat count.
5. REPEAT_EN=0 with the same 60-cycle hold → long_hold still asserts at cycle 26; tick_out pulses exactly once.
6. Reset mid-repeat: assert reset_n=0 at cycle 40 of a hold → outputs 0 on the next edge, no release_tick. After reset is released with the button still held, a fresh press_tick follows 6 cycles later.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Signal bundle between a raw pushbutton and its conditioner.
// master = conditioner side, slave = button source / tick consumer.
interface button_conditioner_if;
  logic button_in;
  logic tick_out;
  logic press_tick;
  logic release_tick;
  logic held;
  logic long_hold;

  modport master (
    input  button_in,
    output tick_out,
    output press_tick,
    output release_tick,
    output held,
    output long_hold
  );

  modport slave (
    output button_in,
    input  tick_out,
    input  press_tick,
    input  release_tick,
    input  held,
    input  long_hold
  );
endinterface

// File: rtl/button_conditioner.sv
// Pushbutton front end: 2-flop synchroniser, debounce, press/release ticks,
// long-hold detection and auto-repeat ticks for the watch FSM.
//
// state          | meaning
// S_IDLE         | button released and stable
// S_PRESS_WAIT   | high seen, counting stable samples before accepting press
// S_PRESSED      | debounced press, counting towards long hold
// S_REPEATING    | long hold reached, issuing repeat ticks every REP_CYC
// S_RELEASE_WAIT | low seen while held, counting stable samples before release
module button_conditioner #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100,
  parameter int REPEAT_EN   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  button_conditioner_if.master bus
);

  localparam int DB_RAW   = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int HOLD_RAW = CLK_FREQ / 1000 * HOLD_MS;
  localparam int REP_RAW  = CLK_FREQ / 1000 * REPEAT_MS;

  // Degenerate parameter sets are clamped so every interval lasts at least one cycle.
  localparam int DB_CYC   = (DB_RAW   < 1) ? 1 : DB_RAW;
  localparam int HOLD_CYC = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
  localparam int REP_CYC  = (REP_RAW  < 1) ? 1 : REP_RAW;

  localparam int MAX_AB  = (DB_CYC > HOLD_CYC) ? DB_CYC : HOLD_CYC;
  localparam int MAX_CYC = (MAX_AB > REP_CYC) ? MAX_AB : REP_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] DB_TC   = CW'(DB_CYC);
  localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_TC  = CW'(REP_CYC - 1);
  localparam logic          REP_ON  = (REPEAT_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_PRESSED,
    S_REPEATING,
    S_RELEASE_WAIT
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_sync1, r_sync2;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] r_hold_cnt, w_hold_nxt;
  logic [CW-1:0] r_rep_cnt, w_rep_nxt;
  logic          r_press_tick, w_press_nxt;
  logic          r_release_tick, w_release_nxt;
  logic          r_tick_out, w_tick_nxt;
  logic          w_rep_tick;
  logic          r_held, w_held_nxt;
  logic          r_long_hold, w_long_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1        <= 1'b0;
      r_sync2        <= 1'b0;
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_hold_cnt     <= '0;
      r_rep_cnt      <= '0;
      r_press_tick   <= 1'b0;
      r_release_tick <= 1'b0;
      r_tick_out     <= 1'b0;
      r_held         <= 1'b0;
      r_long_hold    <= 1'b0;
    end else begin
      r_sync1        <= bus.button_in;
      r_sync2        <= r_sync1;
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_hold_cnt     <= w_hold_nxt;
      r_rep_cnt      <= w_rep_nxt;
      r_press_tick   <= w_press_nxt;
      r_release_tick <= w_release_nxt;
      r_tick_out     <= w_tick_nxt;
      r_held         <= w_held_nxt;
      r_long_hold    <= w_long_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hold_nxt    = r_hold_cnt;
    w_rep_nxt     = r_rep_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_rep_tick    = 1'b0;
    w_held_nxt    = r_held;
    w_long_nxt    = r_long_hold;

    case (r_state)
      S_IDLE: begin
        if (r_sync2) begin
          w_state_nxt = S_PRESS_WAIT;
          w_cnt_nxt   = CW'(1);
        end
      end

      S_PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_TC) begin
          w_state_nxt = S_PRESSED;
          w_press_nxt = 1'b1;
          w_held_nxt  = 1'b1;
          w_hold_nxt  = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_PRESSED: begin
        if (!r_sync2) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = CW'(1);
        end else if (r_hold_cnt == HOLD_TC) begin
          w_state_nxt = S_REPEATING;
          w_long_nxt  = 1'b1;
          w_rep_nxt   = '0;
          w_rep_tick  = REP_ON;
        end else begin
          w_hold_nxt = r_hold_cnt + CW'(1);
        end
      end

      S_REPEATING: begin
        if (!r_sync2) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = CW'(1);
        end else if (r_rep_cnt == REP_TC) begin
          w_rep_tick = REP_ON;
          w_rep_nxt  = '0;
        end else begin
          w_rep_nxt = r_rep_cnt + CW'(1);
        end
      end

      S_RELEASE_WAIT: begin
        // A bounce back high resumes the hold/repeat timers where they stopped.
        if (r_sync2) begin
          w_state_nxt = r_long_hold ? S_REPEATING : S_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DB_TC) begin
          w_state_nxt   = S_IDLE;
          w_release_nxt = 1'b1;
          w_held_nxt    = 1'b0;
          w_long_nxt    = 1'b0;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_held_nxt  = 1'b0;
        w_long_nxt  = 1'b0;
      end
    endcase

    w_tick_nxt = w_press_nxt | w_rep_tick;
  end

  assign bus.tick_out     = r_tick_out;
  assign bus.press_tick   = r_press_tick;
  assign bus.release_tick = r_release_tick;
  assign bus.held         = r_held;
  assign bus.long_hold    = r_long_hold;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: one instance with auto-repeat, one without,
// both fed the same button; expected events are queued as stimulus is driven.
module tb_button_conditioner;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_REPEAT  = 2;
  localparam int K_LONG    = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic button;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ticks [2];
  logic lh_prev [2];

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t q_a [$];
  ev_t q_b [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_conditioner_if bif_a ();
  button_conditioner_if bif_b ();

  assign bif_a.button_in = button;
  assign bif_b.button_in = button;

  button_conditioner #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(4), .HOLD_MS(20), .REPEAT_MS(5), .REPEAT_EN(1)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bif_a)
  );

  button_conditioner #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(4), .HOLD_MS(20), .REPEAT_MS(5), .REPEAT_EN(0)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bif_b)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic string kind_name(input int kind);
    case (kind)
      K_PRESS:   return "press";
      K_RELEASE: return "release";
      K_REPEAT:  return "repeat";
      default:   return "long_hold";
    endcase
  endfunction

  task automatic push_ev(input int d, input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic score(input int d, input int kind);
    ev_t   e;
    string tag;
    int    depth;
    tag   = {(d == 0) ? "a_" : "b_", kind_name(kind)};
    depth = (d == 0) ? q_a.size() : q_b.size();
    if (depth == 0) begin
      check_val({tag, "_unexpected_at"}, cyc, -1);
    end else begin
      if (d == 0) e = q_a.pop_front();
      else        e = q_b.pop_front();
      check_val({tag, "_kind"}, kind, e.kind);
      check_val({tag, "_cycle"}, cyc, e.at);
    end
  endtask

  // Observed order within a cycle: press, release, repeat, long_hold rise.
  task automatic monitor(input int d, input logic pt, input logic rt, input logic to,
                         input logic hd, input logic lh);
    string pfx;
    pfx = (d == 0) ? "a_" : "b_";
    if (to === 1'b1) ticks[d]++;
    if (pt === 1'b1) begin
      score(d, K_PRESS);
      check_val({pfx, "press_tick_out"}, int'(to), 1);
      check_val({pfx, "press_held"}, int'(hd), 1);
    end
    if (rt === 1'b1) begin
      score(d, K_RELEASE);
      check_val({pfx, "release_held"}, int'(hd), 0);
      check_val({pfx, "release_long_hold"}, int'(lh), 0);
    end
    if (to === 1'b1 && pt !== 1'b1) score(d, K_REPEAT);
    if (lh === 1'b1 && lh_prev[d] !== 1'b1) score(d, K_LONG);
    lh_prev[d] = lh;
  endtask

  always @(negedge clk) begin
    monitor(0, bif_a.press_tick, bif_a.release_tick, bif_a.tick_out, bif_a.held, bif_a.long_hold);
    monitor(1, bif_b.press_tick, bif_b.release_tick, bif_b.tick_out, bif_b.held, bif_b.long_hold);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Button seen high from the drive at cycle k until the drive low at cycle k+n.
  task automatic hold_events(input int k, input int n);
    push_ev(0, K_PRESS, k + 7);
    push_ev(1, K_PRESS, k + 7);
    if (n > 24) begin
      for (int t = k + 27; t < k + n + 3; t += 5) begin
        push_ev(0, K_REPEAT, t);
        if (t == k + 27) push_ev(0, K_LONG, t);
      end
      push_ev(1, K_LONG, k + 27);
    end
    push_ev(0, K_RELEASE, k + n + 7);
    push_ev(1, K_RELEASE, k + n + 7);
  endtask

  task automatic check_drained(input string tag);
    check_val({tag, "_pending_a"}, q_a.size(), 0);
    check_val({tag, "_pending_b"}, q_b.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_outs_a"}, int'({bif_a.tick_out, bif_a.press_tick, bif_a.release_tick,
                                      bif_a.held, bif_a.long_hold}), 0);
    check_val({tag, "_outs_b"}, int'({bif_b.tick_out, bif_b.press_tick, bif_b.release_tick,
                                      bif_b.held, bif_b.long_hold}), 0);
  endtask

  task automatic press_for(input string tag, input int n);
    int k;
    k      = cyc;
    button = 1'b1;
    hold_events(k, n);
    wait_cyc(n);
    button = 1'b0;
    wait_cyc(12);
    check_drained(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    lh_prev[0] = 1'b0;
    lh_prev[1] = 1'b0;
    ticks[0]   = 0;
    ticks[1]   = 0;

    // Reset with the button already held
    reset_n = 1'b0;
    button  = 1'b1;
    wait_cyc(3);
    check_idle("reset");
    reset_n = 1'b1;
    k = cyc;
    hold_events(k, 10);
    wait_cyc(10);
    button = 1'b0;
    wait_cyc(12);
    check_drained("reset_press");

    // Clean press held 10 cycles
    ticks[0] = 0;
    press_for("clean", 10);
    check_val("clean_tick_count", ticks[0], 1);

    // Short bounces never qualify
    button = 1'b1;
    wait_cyc(1);
    button = 1'b0;
    wait_cyc(1);
    button = 1'b1;
    wait_cyc(2);
    button = 1'b0;
    wait_cyc(12);
    check_val("bounce_held", int'(bif_a.held), 0);
    check_drained("bounce");

    // Three-cycle low glitch while held
    k      = cyc;
    button = 1'b1;
    push_ev(0, K_PRESS, k + 7);
    push_ev(1, K_PRESS, k + 7);
    push_ev(0, K_RELEASE, k + 29);
    push_ev(1, K_RELEASE, k + 29);
    wait_cyc(12);
    button = 1'b0;
    wait_cyc(3);
    button = 1'b1;
    wait_cyc(5);
    check_val("glitch_held", int'(bif_a.held), 1);
    wait_cyc(2);
    button = 1'b0;
    wait_cyc(12);
    check_drained("glitch");

    // Hold boundaries around long_hold
    press_for("hold24", 24);
    press_for("hold25", 25);

    // Long hold: repeats on a, a single tick on b
    ticks[0] = 0;
    ticks[1] = 0;
    press_for("long", 60);
    check_val("long_ticks_a", ticks[0], 9);
    check_val("long_ticks_b", ticks[1], 1);

    // Reset in the middle of repeating, button kept held
    k      = cyc;
    button = 1'b1;
    push_ev(0, K_PRESS, k + 7);
    push_ev(1, K_PRESS, k + 7);
    push_ev(0, K_REPEAT, k + 27);
    push_ev(0, K_LONG, k + 27);
    push_ev(1, K_LONG, k + 27);
    push_ev(0, K_REPEAT, k + 32);
    push_ev(0, K_REPEAT, k + 37);
    wait_cyc(40);
    reset_n = 1'b0;
    wait_cyc(1);
    check_idle("mid_reset");
    wait_cyc(2);
    reset_n = 1'b1;
    k = cyc;
    hold_events(k, 10);
    wait_cyc(10);
    button = 1'b0;
    wait_cyc(12);
    check_drained("mid_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
